// File: rtl/reg_status_table.sv
// ---------------------------------------------------------------------------
// reg_status_table
//
// Register status table for the scoreboard dispatch stage. Holds one busy bit
// and one producer FU tag per architectural register, answers operand hazard
// lookups for dispatch, allocates destination registers on dispatch and
// releases them from several writeback ports (each matched against the stored
// tag). Also provides flush, an occupancy counter and stale-writeback pulses.
//
// Parameters:
//   NREGS    number of tracked registers
//   TAG_W    producer FU tag width
//   NWB      number of writeback release ports
//   NRD      number of lookup ports
//   ZERO_REG when 1, register index 0 never becomes busy and reads as 0
//
// Ports:
//   CLK       rising-edge clock
//   nRST      asynchronous active-low reset
//   flush     clear every entry at the next edge (other inputs discarded)
//   di_en     dispatch allocate strobe
//   di_rd     dispatch destination register
//   di_tag    dispatch producer FU tag
//   wb_en     per-port release strobe
//   wb_rd     per-port release register, port k at [k*IDX_W +: IDX_W]
//   wb_tag    per-port release tag,      port k at [k*TAG_W +: TAG_W]
//   rd_idx    lookup indices,            port j at [j*IDX_W +: IDX_W]
//   rd_busy   busy bit of each looked-up entry
//   rd_tag    tag of each looked-up entry, port j at [j*TAG_W +: TAG_W]
//   busy_vec  all busy bits
//   busy_cnt  registered population count of busy_vec
//   wb_stale  registered one-cycle pulse: port k released a non-matching entry
//
// Build option:
//   RST_BYPASS_EN  when defined, rd_busy reflects same-cycle matching releases
//                  so a dependent op can issue one cycle earlier. Flush and
//                  dispatch are never bypassed. When undefined, lookups are
//                  pure state reads.
// ---------------------------------------------------------------------------
module reg_status_table #(
    parameter  int NREGS    = 32,
    parameter  int TAG_W    = 2,
    parameter  int NWB      = 2,
    parameter  int NRD      = 3,
    parameter  int ZERO_REG = 1,
    localparam int IDX_W    = $clog2(NREGS),
    localparam int CNT_W    = $clog2(NREGS + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   flush,
    input  logic                   di_en,
    input  logic [IDX_W-1:0]       di_rd,
    input  logic [TAG_W-1:0]       di_tag,
    input  logic [NWB-1:0]         wb_en,
    input  logic [NWB*IDX_W-1:0]   wb_rd,
    input  logic [NWB*TAG_W-1:0]   wb_tag,
    input  logic [NRD*IDX_W-1:0]   rd_idx,
    output logic [NRD-1:0]         rd_busy,
    output logic [NRD*TAG_W-1:0]   rd_tag,
    output logic [NREGS-1:0]       busy_vec,
    output logic [CNT_W-1:0]       busy_cnt,
    output logic [NWB-1:0]         wb_stale
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NREGS-1:0] busy_q;
    logic [TAG_W-1:0] tag_q [NREGS];
    logic [CNT_W-1:0] cnt_q;
    logic [NWB-1:0]   stale_q;

    // Set on the first edge after reset release; state only updates once it
    // is high, so the first update lands on the second rising edge.
    logic             run_q;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Indices at or above NREGS (non power-of-two depth) do not exist.
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < (IDX_W + 1)'(NREGS));
    endfunction

    function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // -----------------------------------------------------------------------
    // Writeback matching
    // Every port compares against the current state, so several ports naming
    // the same index simply set the same clear bit.
    // -----------------------------------------------------------------------
    logic [NWB-1:0]   wb_match;
    logic [NREGS-1:0] clear_vec;

    always_comb begin
        logic [IDX_W-1:0] widx;
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it holding its old value and no latch is inferred.
        wb_match  = '0;
        clear_vec = '0;
        widx      = '0;
        for (int k = 0; k < NWB; k++) begin
            widx = wb_rd[k*IDX_W +: IDX_W];
            if (wb_en[k] && in_range(widx) && busy_q[widx] &&
                (tag_q[widx] == wb_tag[k*TAG_W +: TAG_W])) begin
                wb_match[k]     = 1'b1;
                clear_vec[widx] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Dispatch and next busy state
    // Dispatch is applied after release, so a same-index dispatch wins.
    // -----------------------------------------------------------------------
    logic             disp_ok;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_d;

    assign disp_ok = di_en && in_range(di_rd) && !is_zero_reg(di_rd);

    always_comb begin
        set_vec = '0;
        if (disp_ok) begin
            set_vec[di_rd] = 1'b1;
        end
    end

    assign busy_d = (busy_q & ~clear_vec) | set_vec;

    // -----------------------------------------------------------------------
    // Occupancy counter
    // Only bits that were busy can appear in clear_vec; a cleared bit that is
    // re-dispatched in the same cycle stays busy and counts neither way.
    // -----------------------------------------------------------------------
    logic [NREGS-1:0] clr_eff;
    logic [CNT_W-1:0] n_clr;
    logic             n_inc;
    logic [CNT_W-1:0] cnt_d;

    assign clr_eff = clear_vec & ~set_vec;
    assign n_inc   = disp_ok && !busy_q[di_rd];

    always_comb begin
        n_clr = '0;
        for (int i = 0; i < NREGS; i++) begin
            n_clr = n_clr + CNT_W'(clr_eff[i]);
        end
    end

    assign cnt_d = cnt_q + CNT_W'(n_inc) - n_clr;

    // -----------------------------------------------------------------------
    // Stale writeback: strobe with no matching busy entry.
    // -----------------------------------------------------------------------
    logic [NWB-1:0] stale_d;

    assign stale_d = wb_en & ~wb_match;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!nRST) begin
            run_q   <= 1'b0;
            busy_q  <= '0;
            cnt_q   <= '0;
            stale_q <= '0;
            // NOTE: the tag array is reset here because lookups must read a
            // zero tag straight out of reset; arrays without that need would
            // be left unreset.
            for (int i = 0; i < NREGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                if (flush) begin
                    busy_q  <= '0;
                    cnt_q   <= '0;
                    stale_q <= '0;
                    for (int i = 0; i < NREGS; i++) begin
                        tag_q[i] <= '0;
                    end
                end else begin
                    busy_q  <= busy_d;
                    cnt_q   <= cnt_d;
                    stale_q <= stale_d;
                    // Release keeps the tag; only dispatch rewrites it.
                    if (disp_ok) begin
                        tag_q[di_rd] <= di_tag;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lookups
    // -----------------------------------------------------------------------
    logic [NREGS-1:0] busy_view;

`ifdef RST_BYPASS_EN
    // Same-cycle matching releases read not-busy; dispatch and flush are not
    // forwarded, so a released-and-redispatched entry also reads not-busy.
    assign busy_view = busy_q & ~clear_vec;
`else
    assign busy_view = busy_q;
`endif

    always_comb begin
        logic [IDX_W-1:0] ridx;
        rd_busy = '0;
        rd_tag  = '0;
        ridx    = '0;
        for (int j = 0; j < NRD; j++) begin
            ridx = rd_idx[j*IDX_W +: IDX_W];
            if (in_range(ridx) && !is_zero_reg(ridx)) begin
                rd_busy[j]                = busy_view[ridx];
                rd_tag[j*TAG_W +: TAG_W]  = tag_q[ridx];
            end
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;
    assign wb_stale = stale_q;

endmodule
